// File: rtl/irq_pkg.sv
// irq_pkg: register map, bus FSM states and ID-width helper shared by the irq_ctrl slice
package irq_pkg;
  localparam logic [7:0] IRQ_ADDR_ENABLE  = 8'h40;
  localparam logic [7:0] IRQ_ADDR_PENDING = 8'h41;
  localparam logic [7:0] IRQ_ADDR_THRESH  = 8'h42;
  localparam logic [7:0] IRQ_ADDR_CLAIM   = 8'h43;
  localparam logic [7:0] IRQ_ADDR_EDGE    = 8'h44;
  typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_e;
  function automatic int id_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/irq_gateway.sv
// irq_gateway: per-source pending/in-flight tracking; edge detector only with IRQ_CTRL_EDGE_EN
module irq_gateway (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_mode,
  input  logic claim_clr,
  input  logic complete_clr,
  output logic pending
);
  logic inflight, edge_set, level_set;
`ifdef IRQ_CTRL_EDGE_EN
  logic prev;
  always_ff @(posedge clk or negedge rst)
    if (!rst) prev <= 1'b0;
    else prev <= src;
  assign edge_set = edge_mode & src & ~prev;
`else
  logic unused_edge;
  assign unused_edge = edge_mode;
  assign edge_set = 1'b0;
`endif
  assign level_set = ~edge_mode & src & ~inflight;
  // an edge in the claim cycle survives the clear; a level request does not
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pending  <= 1'b0;
      inflight <= 1'b0;
    end else begin
      pending  <= edge_set | ((pending | level_set) & ~claim_clr);
      inflight <= claim_clr | (inflight & ~complete_clr);
    end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised multi-source interrupt controller with claim/complete register bus
// Optional edge-mode sources when IRQ_CTRL_EDGE_EN is defined.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic               bus_en,
  input  logic               bus_we,
  input  logic [7:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               bus_ack,
  output logic               ei
);
  localparam int IW = id_w(NUM_SRC);
  logic [PRIO_W-1:0]  prio [NUM_SRC];
  logic [PRIO_W-1:0]  thresh, best_p;
  logic [NUM_SRC-1:0] enable, pending, edge_mode, claim_clr, complete_clr;
  logic [IW-1:0]      best_id, best_nx;
  logic [31:0]        rd_val;
  logic               accept, wr, rd, unused_wdata;
  bus_state_e         state, state_nx;
  assign unused_wdata = ^bus_wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= BUS_IDLE;
    else state <= state_nx;
  always_comb begin
    accept   = bus_en && state == BUS_IDLE;
    state_nx = accept ? BUS_ACK : BUS_IDLE;
  end
  assign bus_ack = state == BUS_ACK;
  assign wr = accept & bus_we;
  assign rd = accept & ~bus_we;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign claim_clr[g]    = rd && bus_addr == IRQ_ADDR_CLAIM && best_id == IW'(g + 1);
    assign complete_clr[g] = wr && bus_addr == IRQ_ADDR_CLAIM && bus_wdata[7:0] == 8'(g + 1);
    irq_gateway u_gw (
      .clk(clk), .rst(rst), .src(src[g]), .edge_mode(edge_mode[g]),
      .claim_clr(claim_clr[g]), .complete_clr(complete_clr[g]), .pending(pending[g])
    );
  end
`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] edge_mask;
  always_ff @(posedge clk or negedge rst)
    if (!rst) edge_mask <= '0;
    else if (wr && bus_addr == IRQ_ADDR_EDGE) edge_mask <= bus_wdata[NUM_SRC-1:0];
  assign edge_mode = edge_mask;
`else
  assign edge_mode = '0;
`endif
  // strict compare keeps the lowest ID on priority ties
  always_comb begin
    best_nx = '0;
    best_p  = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (pending[i] && enable[i] && prio[i] > thresh && prio[i] > best_p) begin
        best_nx = IW'(i + 1);
        best_p  = prio[i];
      end
  end
  always_comb begin
    rd_val = bus_addr == IRQ_ADDR_ENABLE  ? 32'(enable)  :
             bus_addr == IRQ_ADDR_PENDING ? 32'(pending) :
             bus_addr == IRQ_ADDR_THRESH  ? 32'(thresh)  :
             bus_addr == IRQ_ADDR_CLAIM   ? 32'(best_id) :
             bus_addr == IRQ_ADDR_EDGE    ? 32'(edge_mode) : '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (bus_addr == 8'(i + 1)) rd_val = 32'(prio[i]);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
      enable    <= '0;
      thresh    <= '0;
      best_id   <= '0;
      bus_rdata <= '0;
    end else begin
      best_id   <= best_nx;
      bus_rdata <= rd ? rd_val : '0;
      if (wr) begin
        for (int i = 0; i < NUM_SRC; i++)
          if (bus_addr == 8'(i + 1)) prio[i] <= bus_wdata[PRIO_W-1:0];
        if (bus_addr == IRQ_ADDR_ENABLE) enable <= bus_wdata[NUM_SRC-1:0];
        if (bus_addr == IRQ_ADDR_THRESH) thresh <= bus_wdata[PRIO_W-1:0];
      end
    end
  assign ei = best_id != '0;
endmodule
